icache_dm: RTL and testbench
============================

# icache_dm

Parametrised direct-mapped instruction cache between the fetch stage and the instruction-memory bus. A fetch request returns a 32-bit word in 2 cycles on a hit. A miss triggers a line refill of LINE_WORDS beats from a word-wide memory port. Data-side stores snoop the cache and invalidate matching lines, and a flush input clears all lines.

## Interface
- ADDR_W, 32, byte-address width
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- SETS, 64, number of lines; power of two, ≥2
- Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = ADDR_W-OFF_W-IDX_W

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request
- req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- req_ready  out  1  cache can accept a request this cycle
- resp_valid  out  1  one-cycle pulse; resp_data valid
- resp_data  out  32  fetched word
- mem_req_valid  out  1  refill request
- mem_req_addr  out  ADDR_W  line-aligned refill address (low OFF_W bits 0)
- mem_req_ready  in  1  memory accepts refill request
- mem_resp_valid  in  1  refill beat valid
- mem_resp_data  in  32  refill beat; beats arrive in ascending word order
- snoop_we  in  1  data-side store
- snoop_addr  in  ADDR_W  store byte address
- flush  in  1  invalidate all lines

## Operation
- Address split: tag = [ADDR_W-1 : OFF_W+IDX_W], index = [OFF_W+IDX_W-1 : OFF_W], word = [OFF_W-1 : 2].
- Storage:
  - valid bit per set
  - tag array of SETS×TAG_W
  - data array of SETS×LINE_WORDS×32
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE:
  - req_ready = 1 unless a flush is pending.
  - On req_valid & req_ready, register the address and read tag/data/valid at that index, then go to LOOKUP.
- LOOKUP:
  - Hit = valid & tag equal & no snoop to this index in this cycle.
  - Hit: resp_data ← selected word, resp_valid = 1 next cycle, go to IDLE.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid = 1, with mem_req_addr = {tag, index, OFF_W'b0}.
  - Hold both stable until mem_req_ready, then go to REFILL with beat counter = 0.
- REFILL:
  - Each mem_resp_valid writes the beat into data[index][counter], and the counter increments.
  - The beat whose counter equals the requested word is captured into resp_data.
  - On the last beat (counter = LINE_WORDS-1): write the tag, set valid = ¬stale, go to RESP.
- RESP: resp_valid = 1 for one cycle, then go to IDLE.
- Snoop:
  - When snoop_we is high, valid[snoop index] is cleared in that cycle, provided the stored tag matches (tag match required).
  - If the snoop index and tag equal the line under refill in MISS_REQ/REFILL, set the stale flag. The response is still delivered, but the line is left invalid.
- Flush:
  - In IDLE with no acceptance, all valid bits clear in 1 cycle.
  - Otherwise flush is latched as pending and applied on the first IDLE cycle.
  - req_ready = 0 during that cycle.
  - Flush and req_valid in the same IDLE cycle: flush wins, and the request is not accepted.
- Reset:
  - state = IDLE; all valid = 0; stale = 0; flush pending = 0; counter = 0.
  - resp_valid = 0, resp_data = 0, mem_req_valid = 0, mem_req_addr = 0.
  - req_ready = 1 the cycle after reset releases.
  - Reset mid-refill abandons the refill, and later beats are ignored in IDLE.
- mem_resp_valid outside REFILL is ignored. resp has no backpressure.

## Timing
- Hit: accept at cycle T, LOOKUP at T+1, resp_valid at T+2. Next accept is possible at T+2, giving 1 fetch per 2 cycles.
- Miss: mem_req_valid from T+2. Handshake at cycle H. Beats from H+1 onward (any gaps). Last beat at cycle L, resp_valid at L+1, req_ready at L+2.
- Snoop in the same cycle as a lookup of the same index forces a miss. The clear and the lookup do not race.
- resp_valid is never high for 2 consecutive cycles.
- mem_req_valid never drops before mem_req_ready.

## Test plan
- Cold miss: LINE_WORDS=4. Fetch 0x104 after reset.
  - mem_req_addr = 0x100.
  - Beats 0xA0..0xA3 produce resp_data = 0xA1 one cycle after the last beat.
  - A refetch of 0x10C hits, with resp_data = 0xA3 two cycles after acceptance and no mem_req.
- Conflict: SETS=64, line 16 B. Fetch 0x100, then 0x500 (same index, different tag).
  - Both miss.
  - A refetch of 0x100 misses again.
- Snoop:
  - After filling 0x100, snoop_we to 0x108, then fetch 0x100: miss and refill.
  - Snoop to 0x508 leaves 0x100 hitting.
- Snoop during refill: snoop the refill line mid-REFILL.
  - The response is still correct.
  - The next fetch of the same address misses.
- Flush:
  - flush asserted during REFILL: response delivered, one cycle with req_ready = 0, then all prior lines miss.
  - flush with req_valid in IDLE: request not accepted that cycle.
- Reset mid-refill: rst_n low after 2 beats.
  - All outputs are 0.
  - Stray beats are ignored.
  - The refetch misses and refills correctly; mem_req_ready is held low for 5 cycles to check mem_req_valid/mem_req_addr stay stable.

Source files
------------

// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
// icache_dm_if
// ----------------------------------------------------------------------------
// Bus bundle for icache_dm: fetch request/response channel plus the
// word-wide instruction-memory refill channel.
//   slave  : cache view (accepts fetches, issues refills)
//   master : environment view (fetch stage + instruction memory)
// Signals:
//   req_valid/req_addr/req_ready      fetch request handshake
//   resp_valid/resp_data              one-cycle fetch response
//   mem_req_valid/mem_req_addr/
//   mem_req_ready                     line refill request handshake
//   mem_resp_valid/mem_resp_data      refill beats, ascending word order
// Revision: 1.0 - initial release
// ============================================================================
interface icache_dm_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// icache_dm
// ----------------------------------------------------------------------------
// Direct-mapped instruction cache. Hits respond two cycles after acceptance;
// misses refill a whole line of LINE_WORDS beats from the memory port.
// Data-side stores snoop-invalidate matching lines; flush clears all lines.
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   bus          icache_dm_if.slave: fetch channel + refill channel
//   snoop_we     data-side store strobe
//   snoop_addr   data-side store byte address
//   flush        invalidate every line
// Revision: 1.0 - initial release
// ============================================================================
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_dm_if.slave        bus,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              flush
);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int OFF_W = WRD_W + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [WRD_W-1:0]  beat_cnt;
    logic              stale;
    logic              flush_pend;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [31:0]       data_mem [SETS*LINE_WORDS];

    logic              resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic              req_ready_c;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WRD_W-1:0]  req_word;
    logic [TAG_W-1:0]  snp_tag;
    logic [IDX_W-1:0]  snp_idx;

    assign req_tag  = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign req_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_word = addr_q[OFF_W-1:2];
    assign snp_tag  = snoop_addr[ADDR_W-1:OFF_W+IDX_W];
    assign snp_idx  = snoop_addr[OFF_W+IDX_W-1:OFF_W];

    // Byte-offset bits carry no information for a word cache.
    logic unused_ok;
    assign unused_ok = ^{addr_q[1:0], snoop_addr[OFF_W-1:0]};

    logic accept, hit, snoop_refill, beat, last_beat, flush_now, snoop_clear;

    assign accept    = bus.req_valid && req_ready_c;
    // A store to the looked-up index forces a miss regardless of tag, so the
    // lookup never has to race the snoop invalidation.
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag)
                       && !(snoop_we && (snp_idx == req_idx));
    assign snoop_refill = snoop_we && (snp_idx == req_idx) && (snp_tag == req_tag)
                          && ((state == MISS_REQ) || (state == REFILL));
    assign snoop_clear  = snoop_we && valid[snp_idx] && (tag_mem[snp_idx] == snp_tag);
    assign beat      = (state == REFILL) && bus.mem_resp_valid;
    assign last_beat = beat && (beat_cnt == LAST_BEAT);
    assign flush_now = (state == IDLE) && (flush || flush_pend);

    assign bus.req_ready     = req_ready_c;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = rst_n && !flush && !flush_pend;
                if (bus.req_valid && req_ready_c) state_nxt = LOOKUP;
            end
            LOOKUP:   state_nxt = hit ? IDLE : MISS_REQ;
            MISS_REQ: if (bus.mem_req_ready) state_nxt = REFILL;
            REFILL:   if (last_beat) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_q          <= '0;
            beat_cnt        <= '0;
            stale           <= 1'b0;
            flush_pend      <= 1'b0;
            valid           <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state        <= state_nxt;
            resp_valid_q <= 1'b0;

            if (accept) addr_q <= bus.req_addr;

            if (state == LOOKUP) begin
                if (hit) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= data_mem[{req_idx, req_word}];
                end else begin
                    mem_req_valid_q <= 1'b1;
                    mem_req_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    stale           <= 1'b0;
                end
            end

            if ((state == MISS_REQ) && bus.mem_req_ready) begin
                mem_req_valid_q <= 1'b0;
                beat_cnt        <= '0;
            end

            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == req_word) resp_data_q <= bus.mem_resp_data;
            end
            if (last_beat) resp_valid_q <= 1'b1;

            if (snoop_refill) stale <= 1'b1;

            if (flush && (state != IDLE)) flush_pend <= 1'b1;
            else if (flush_now)          flush_pend <= 1'b0;

            // Snoop clear sits before the refill write so a store hitting the
            // old tag of a line being replaced cannot kill the new line.
            if (snoop_clear) valid[snp_idx] <= 1'b0;
            if (flush_now)   valid <= '0;
            if (last_beat)   valid[req_idx] <= !(stale || snoop_refill);
        end
    end

    // Storage arrays need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst_n && beat) data_mem[{req_idx, beat_cnt}] <= bus.mem_resp_data;
        if (rst_n && last_beat) tag_mem[req_idx] <= req_tag;
    end
endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// tb_icache_dm
// ----------------------------------------------------------------------------
// Directed bench for icache_dm (ADDR_W=32, LINE_WORDS=4, SETS=64). Stimulus
// pushes expected responses / refill addresses into queues; independent
// monitors pop and compare whenever the DUT presents them.
// Memory model word at byte address a: (a>>2) + 0x60 + (ver<<12).
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache_dm;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snoop_we;
    logic [31:0] snoop_addr;
    logic        flush;

    always #5 clk = ~clk;

    icache_dm_if #(.ADDR_W(32)) bus ();

    icache_dm #(.ADDR_W(32), .LINE_WORDS(LW), .SETS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .flush      (flush)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        rq[$];
    logic [31:0] mq[$];
    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    logic [31:0] ver    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timed out, required event within 20 cycles (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a >> 2) + 32'h60 + (ver << 12);
    endfunction

    // Response monitor
    logic prev_rv = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk); #1;
        if (bus.resp_valid) begin
            chk("resp_back_to_back", {31'b0, prev_rv}, 32'd0);
            if (rq.size() == 0) begin
                total++;
                $display("FAIL resp_unexpected: got data %h, required no response (cycle %0d)",
                         bus.resp_data, cyc);
            end else begin
                e = rq.pop_front();
                chk("resp_data", bus.resp_data, e.data);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
        prev_rv = bus.resp_valid;
    end

    // Refill request monitor
    logic        prev_mv = 1'b0;
    logic        prev_mr = 1'b0;
    logic [31:0] prev_ma = '0;
    initial forever begin
        @(negedge clk); #1;
        if (rst_n) begin
            if (bus.mem_req_valid && !prev_mv && mq.size() == 0) begin
                total++;
                $display("FAIL mem_req_unexpected: got addr %h, required no request (cycle %0d)",
                         bus.mem_req_addr, cyc);
            end
            if (prev_mv && !prev_mr) begin
                chk("mem_req_hold_valid", {31'b0, bus.mem_req_valid}, 32'd1);
                chk("mem_req_hold_addr", bus.mem_req_addr, prev_ma);
            end
            if (bus.mem_req_valid && bus.mem_req_ready && mq.size() > 0)
                chk("mem_req_addr", bus.mem_req_addr, mq.pop_front());
        end
        prev_mv = rst_n && bus.mem_req_valid;
        prev_mr = bus.mem_req_ready;
        prev_ma = bus.mem_req_addr;
    end

    // mode: 0 plain, 1 snoop during LOOKUP, 2 snoop mid-refill, 3 flush mid-refill
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit miss,
                         input int mode, input logic [31:0] saddr, input int rdy_dly,
                         input int abort_at);
        int          c0;
        int          t;
        int          last;
        logic [31:0] line;
        line = a & 32'hFFFF_FFF0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        t = 0;
        while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
        if (!bus.req_ready) begin timeout("req_ready_wait"); bus.req_valid = 1'b0; return; end
        c0 = cyc;
        if (miss) mq.push_back(line);
        else      rq.push_back('{exp, c0 + 2});
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (mode == 1) begin
            snoop_we = 1'b1; snoop_addr = saddr;
            @(negedge clk);
            snoop_we = 1'b0;
        end
        if (!miss) return;
        t = 0;
        while (!bus.mem_req_valid && t < 20) begin @(negedge clk); t++; end
        if (!bus.mem_req_valid) begin timeout("mem_req_wait"); return; end
        repeat (rdy_dly) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        last = 0;
        for (int i = 0; i < LW; i++) begin
            if (abort_at > 0 && i == abort_at) begin bus.mem_resp_valid = 1'b0; return; end
            if (i == 2 && mode >= 2) begin
                bus.mem_resp_valid = 1'b0;
                if (mode == 2) begin snoop_we = 1'b1; snoop_addr = saddr; end
                else flush = 1'b1;
                @(negedge clk);
                snoop_we = 1'b0; flush = 1'b0;
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = memw(line + 32'(4 * i));
            last = cyc;
            if (i == LW - 1) rq.push_back('{exp, last + 1});
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("req_ready_after_refill", {31'b0, bus.req_ready}, (mode == 3) ? 32'd0 : 32'd1);
        if (mode == 3) begin
            @(negedge clk);
            chk("req_ready_after_flush", {31'b0, bus.req_ready}, 32'd1);
        end
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge clk);
        snoop_we = 1'b1; snoop_addr = a;
        @(negedge clk);
        snoop_we = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; snoop_we = 1'b0; snoop_addr = '0; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

        // Cold miss, then hit in the same line
        fetch(32'h104, 32'hA1, 1, 0, 0, 0, 0);
        fetch(32'h10C, 32'hA3, 0, 0, 0, 0, 0);
        // Conflict on index 16
        fetch(32'h500, 32'h1A0, 1, 0, 0, 0, 0);
        fetch(32'h100, 32'hA0, 1, 0, 0, 0, 0);
        // Snoop with other tag keeps the line; matching snoop kills it
        snoop(32'h508);
        fetch(32'h104, 32'hA1, 0, 0, 0, 0, 0);
        snoop(32'h108);
        ver = 1;
        fetch(32'h100, 32'h10A0, 1, 0, 0, 0, 0);
        // Snoop to the looked-up index during LOOKUP forces a miss
        fetch(32'h104, 32'h10A1, 1, 1, 32'h508, 0, 0);
        fetch(32'h10C, 32'h10A3, 0, 0, 0, 0, 0);
        // Snoop of the line under refill: response good, line left invalid
        fetch(32'h20C, 32'h10E3, 1, 2, 32'h204, 0, 0);
        fetch(32'h200, 32'h10E0, 1, 0, 0, 0, 0);
        fetch(32'h204, 32'h10E1, 0, 0, 0, 0, 0);
        // Flush during refill
        fetch(32'h504, 32'h11A1, 1, 3, 0, 0, 0);
        fetch(32'h504, 32'h11A1, 1, 0, 0, 0, 0);
        fetch(32'h208, 32'h10E2, 1, 0, 0, 0, 0);
        // Flush together with a request in IDLE
        @(negedge clk);
        flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h504;
        #1;
        chk("req_ready_flush_wins", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; bus.req_valid = 1'b0;
        fetch(32'h504, 32'h11A1, 1, 0, 0, 0, 0);
        // Reset after two refill beats
        fetch(32'h200, 32'h10E0, 1, 0, 0, 0, 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset2", {31'b0, bus.req_ready}, 32'd1);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        fetch(32'h20C, 32'h10E3, 1, 0, 0, 5, 0);
        fetch(32'h208, 32'h10E2, 0, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("mem_queue_empty", mq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
